// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Shift-add unsigned multiplier controller that drives a shared
//               external ALU, one ADD per cycle. Optional zero-operand early
//               completion is enabled by defining MUL_ZERO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
  parameter int                WIDTH  = 32,
  parameter int                CTRL_W = 3,
  parameter logic [CTRL_W-1:0] ADD_OP = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  product_hi,
  output logic [WIDTH-1:0]  product_lo,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_c
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_product_hi;
  logic [WIDTH-1:0]   r_product_lo;
  logic               w_run;
  logic               w_bypass;

`ifdef MUL_ZERO_BYPASS_EN
  // A zero operand makes the product trivially zero, so RUN can be skipped.
  assign w_bypass = (op_a == '0) || (op_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_mcand      <= '0;
      r_acc_hi     <= '0;
      r_acc_lo     <= '0;
      r_cnt        <= '0;
      r_product_hi <= '0;
      r_product_lo <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_mcand  <= op_a;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            if (w_bypass) begin
              r_acc_lo <= '0;
              r_state  <= c_st_done;
            end else begin
              r_acc_lo <= op_b;
              r_state  <= c_st_run;
            end
          end
        end
        c_st_run: begin
          // Low accumulator bit selects add-and-shift versus plain shift.
          if (r_acc_lo[0]) begin
            {r_acc_hi, r_acc_lo} <= {alu_c, alu_result, r_acc_lo[WIDTH-1:1]};
          end else begin
            {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[WIDTH-1:1]};
          end
          if (r_cnt == c_cnt_last) begin
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_done: begin
          r_product_hi <= r_acc_hi;
          r_product_lo <= r_acc_lo;
          r_state      <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign w_run      = (r_state == c_st_run);
  assign busy       = (r_state != c_st_idle);
  assign done       = (r_state == c_st_done);
  assign product_hi = r_product_hi;
  assign product_lo = r_product_lo;

  // Operands are forced to zero outside RUN so the shared ALU sees no traffic.
  assign alu_ctrl = ADD_OP;
  assign alu_a    = w_run ? r_acc_hi : '0;
  assign alu_b    = w_run ? r_mcand  : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_sequencer
// Description : Self-checking bench for alu_mul_sequencer with an ALU stub and
//               an arithmetic reference model. Honours MUL_ZERO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  product_hi;
  logic [WIDTH-1:0]  product_lo;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_c;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(
    .WIDTH (WIDTH),
    .CTRL_W(CTRL_W),
    .ADD_OP(3'b000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product_hi(product_hi),
    .product_lo(product_lo),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .alu_c     (alu_c)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU: ADD with carry-out.
  assign {alu_c, alu_result} = (alu_ctrl == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b}) : '0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return WIDTH + 1;
  endfunction

  // Launch one operation; lat counts edges from start sample to done (-1 on timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] prod);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    @(posedge clk);
    #1 prod = {product_hi, product_lo};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if ({product_hi, product_lo} !== 64'h0) begin
      errors++; $display("FAIL reset_product got %h want 0", {product_hi, product_lo});
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== 3'b000) begin
      errors++; $display("FAIL reset_alu got a=%h b=%h ctrl=%b want 0/0/000", alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [63:0] prod;
    do_op(32'd3, 32'd5, lat, prod);
    checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, WIDTH + 1); end
    checks++; if (prod !== 64'hF) begin errors++; $display("FAIL basic_product got %h want %h", prod, 64'hF); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got done=%b busy=%b want 0/0", done, busy); end
    repeat (5) @(negedge clk);
    checks++;
    if ({product_hi, product_lo} !== 64'hF) begin
      errors++; $display("FAIL basic_hold got %h want %h", {product_hi, product_lo}, 64'hF);
    end
  endtask

  task automatic test_carry();
    int lat; logic [63:0] prod;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, prod);
    checks++;
    if (prod !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL carry_product got %h want %h", prod, 64'hFFFF_FFFE_0000_0001);
    end
    checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL carry_latency got %0d want %0d", lat, WIDTH + 1); end
  endtask

  task automatic test_random();
    int lat; logic [63:0] prod;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      do_op(a, b, lat, prod);
      checks++;
      if (prod !== ref_mul(a, b)) begin
        errors++; $display("FAIL random_product a=%h b=%h got %h want %h", a, b, prod, ref_mul(a, b));
      end
      checks++;
      if (lat !== exp_lat(a, b)) begin
        errors++; $display("FAIL random_latency a=%h b=%h got %0d want %0d", a, b, lat, exp_lat(a, b));
      end
    end
  endtask

  task automatic test_ignored_start();
    int lat; logic [63:0] prod;
    int pulses, first;
    pulses = 0; first = -1;
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 10) begin op_a = 32'd9; op_b = 32'd9; start = 1'b1; end
      if (n == 11) start = 1'b0;
      if (done) begin pulses++; if (first < 0) first = n; end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignored_pulses got %0d want 1", pulses); end
    checks++; if (first !== WIDTH + 1) begin errors++; $display("FAIL ignored_latency got %0d want %0d", first, WIDTH + 1); end
    checks++;
    if ({product_hi, product_lo} !== 64'd42) begin
      errors++; $display("FAIL ignored_product got %h want %h", {product_hi, product_lo}, 64'd42);
    end
    do_op(32'd9, 32'd9, lat, prod);
    checks++; if (prod !== 64'd81) begin errors++; $display("FAIL ignored_next got %h want %h", prod, 64'd81); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [63:0] prod;
    int pulses;
    pulses = 0;
    @(negedge clk);
    op_a = 32'h1234; op_b = 32'h10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags got busy=%b done=%b want 0/0", busy, done); end
    checks++;
    if ({product_hi, product_lo} !== 64'h0) begin
      errors++; $display("FAIL midreset_product got %h want 0", {product_hi, product_lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_spurious_done got %0d want 0", pulses); end
    do_op(32'd2, 32'd2, lat, prod);
    checks++; if (prod !== 64'd4) begin errors++; $display("FAIL midreset_next_product got %h want 4", prod); end
    checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL midreset_next_latency got %0d want %0d", lat, WIDTH + 1); end
  endtask

  task automatic test_zero();
    int lat; logic [63:0] prod;
    do_op(32'h0, 32'hDEAD_BEEF, lat, prod);
    checks++; if (prod !== 64'h0) begin errors++; $display("FAIL zero_a_product got %h want 0", prod); end
    checks++;
    if (lat !== exp_lat(32'h0, 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL zero_a_latency got %0d want %0d", lat, exp_lat(32'h0, 32'hDEAD_BEEF));
    end
    do_op(32'd3, 32'd3, lat, prod);
    do_op(32'hDEAD_BEEF, 32'h0, lat, prod);
    checks++; if (prod !== 64'h0) begin errors++; $display("FAIL zero_b_product got %h want 0", prod); end
    checks++;
    if (lat !== exp_lat(32'hDEAD_BEEF, 32'h0)) begin
      errors++; $display("FAIL zero_b_latency got %0d want %0d", lat, exp_lat(32'hDEAD_BEEF, 32'h0));
    end
  endtask

  task automatic test_alu_drive();
    logic [31:0] a, b, m;
    logic [63:0] partial;
    int bad, seen;
    bad = 0; seen = 0;
    a = $urandom | 32'h1;
    b = $urandom | 32'h8000_0001;
    @(negedge clk);
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== 3'b000) begin
      errors++; $display("FAIL alu_idle got a=%h b=%h ctrl=%b want 0/0/000", alu_a, alu_b, alu_ctrl);
    end
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Upper accumulator before iteration i holds the partial product of the low i multiplier bits, shifted right by i.
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      m = (32'h1 << i) - 32'h1;
      partial = ref_mul(a, b & m) >> i;
      if (alu_b !== a || alu_ctrl !== 3'b000 || alu_a !== partial[31:0]) begin
        bad++;
        if (bad == 1) $display("FAIL alu_run iter %0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=000",
                               i, alu_a, alu_b, alu_ctrl, partial[31:0], a);
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL alu_run_cycles got %0d bad want 0", bad); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL alu_done got %0d want 1", seen); end
    @(posedge clk);
    #1;
    checks++;
    if ({product_hi, product_lo} !== ref_mul(a, b)) begin
      errors++; $display("FAIL alu_product got %h want %h", {product_hi, product_lo}, ref_mul(a, b));
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0) begin
      errors++; $display("FAIL alu_after got a=%h b=%h want 0/0", alu_a, alu_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_ignored_start();
    test_reset_mid_op();
    test_zero();
    test_alu_drive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
